mao_placar: RTL and testbench

- Downstream consumer of the per-vaza result logic. It takes one vaza outcome per strobe (player-1 win or tie) and applies the truco best-of-three rules to decide each mão.
- It also runs the truco raise/accept/fold handshake and keeps both players' match scores up to the game target.
- Its outputs drive the score display and the game-over indication.

---
 rtl/mao_placar_pkg.sv | 10 +
 rtl/mao_placar_if.sv | 17 +
 rtl/mao_resolver.sv | 18 +
 rtl/mao_placar.sv | 136 +++++++++++++
 tb/tb_mao_placar.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mao_placar_pkg.sv
// mao_placar_pkg: shared result/state encodings and the truco raise ladder
package mao_placar_pkg;
    typedef enum logic [1:0] {R_NONE = 2'b00, R_P1 = 2'b01, R_P2 = 2'b10, R_TIE = 2'b11} res_t;
    typedef enum logic [1:0] {PLAY, TRUCO_WAIT, AWARD, OVER} state_t;
    localparam logic [3:0] HV_1 = 4'd1, HV_3 = 4'd3, HV_6 = 4'd6, HV_9 = 4'd9, HV_12 = 4'd12;
    localparam int TARGET_DEF = 12;
    function automatic logic [3:0] next_hv(input logic [3:0] hv);
        return hv == HV_1 ? HV_3 : hv == HV_3 ? HV_6 : hv == HV_6 ? HV_9 : HV_12;
    endfunction
endpackage

// File: rtl/mao_placar_if.sv
// mao_placar_if: vaza/truco inputs and score/status outputs of the scoreboard
interface mao_placar_if #(parameter int SCORE_W = 4);
    logic               vaza_valid, v_in, e_in;
    logic               truco_req_p1, truco_req_p2, truco_acc, truco_run;
    logic [SCORE_W-1:0] score1, score2;
    logic [3:0]         hand_value;
    logic [1:0]         vaza_idx, hand_winner;
    logic               truco_pending, hand_done, game_over;
    modport master (
        output vaza_valid, v_in, e_in, truco_req_p1, truco_req_p2, truco_acc, truco_run,
        input  score1, score2, hand_value, vaza_idx, truco_pending, hand_done, hand_winner, game_over
    );
    modport slave (
        input  vaza_valid, v_in, e_in, truco_req_p1, truco_req_p2, truco_acc, truco_run,
        output score1, score2, hand_value, vaza_idx, truco_pending, hand_done, hand_winner, game_over
    );
endinterface

// File: rtl/mao_resolver.sv
// mao_resolver: combinational best-of-three decision for the current mão
module mao_resolver
    import mao_placar_pkg::*;
(
    input  res_t       r1_i,
    input  res_t       r2_i,
    input  res_t       r_i,
    input  logic [1:0] idx_i,
    output logic       decided_o,
    output res_t       winner_o
);
    // Second vaza stays open only on tie-tie or a split of wins
    always_comb begin
        decided_o = idx_i == 2'd2 ||
                    (idx_i == 2'd1 && (r1_i == R_TIE ? r_i != R_TIE : (r_i == R_TIE || r_i == r1_i)));
        winner_o  = r_i != R_TIE ? r_i : r1_i != R_TIE ? r1_i : r2_i != R_TIE ? r2_i : R_NONE;
    end
endmodule

// File: rtl/mao_placar.sv
// mao_placar: truco mão resolution, raise handshake and match scoring
module mao_placar
    import mao_placar_pkg::*;
#(
    parameter int TARGET  = TARGET_DEF,
    parameter int SCORE_W = 4
) (
    input logic         clk,
    input logic         rst_n,
    mao_placar_if.slave bus
);
    localparam int SW1 = SCORE_W + 1;

    state_t             state_q, state_d;
    res_t               r1_q, r1_d, r2_q, r2_d, raiser_q, raiser_d, pend_q, pend_d;
    res_t               win_q, win_d, hw_q, hw_d, res, winner;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic [3:0]         hv_q, hv_d;
    logic [1:0]         idx_q, idx_d;
    logic               done_q, decided, can_raise, full1, full2;
    logic [SW1-1:0]     sum1, sum2;

    assign res       = bus.e_in ? R_TIE : bus.v_in ? R_P1 : R_P2;
    assign can_raise = hv_q != HV_12;
    assign sum1      = {1'b0, score1_q} + (win_q == R_P1 ? SW1'(hv_q) : '0);
    assign sum2      = {1'b0, score2_q} + (win_q == R_P2 ? SW1'(hv_q) : '0);
    assign full1     = sum1 >= SW1'(TARGET);
    assign full2     = sum2 >= SW1'(TARGET);

    mao_resolver u_resolver (
        .r1_i      (r1_q),
        .r2_i      (r2_q),
        .r_i       (res),
        .idx_i     (idx_q),
        .decided_o (decided),
        .winner_o  (winner)
    );

    always_comb begin
        state_d  = state_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        raiser_d = raiser_q;
        pend_d   = pend_q;
        win_d    = win_q;
        hw_d     = hw_q;
        score1_d = score1_q;
        score2_d = score2_q;
        hv_d     = hv_q;
        idx_d    = idx_q;
        case (state_q)
            PLAY: begin
                // A strobed vaza always wins over a raise request in the same cycle
                if (bus.vaza_valid) begin
                    if (decided) begin
                        win_d   = winner;
                        state_d = AWARD;
                    end else if (idx_q == 2'd0) begin
                        r1_d  = res;
                        idx_d = 2'd1;
                    end else begin
                        r2_d  = res;
                        idx_d = 2'd2;
                    end
                end else if (can_raise && bus.truco_req_p1 && raiser_q != R_P1) begin
                    pend_d  = R_P1;
                    state_d = TRUCO_WAIT;
                end else if (can_raise && bus.truco_req_p2 && raiser_q != R_P2) begin
                    pend_d  = R_P2;
                    state_d = TRUCO_WAIT;
                end
            end
            TRUCO_WAIT: begin
                if (bus.truco_run) begin
                    win_d   = pend_q;
                    state_d = AWARD;
                end else if (bus.truco_acc) begin
                    hv_d     = next_hv(hv_q);
                    raiser_d = pend_q;
                    state_d  = PLAY;
                end
            end
            AWARD: begin
                score1_d = full1 ? SCORE_W'(TARGET) : sum1[SCORE_W-1:0];
                score2_d = full2 ? SCORE_W'(TARGET) : sum2[SCORE_W-1:0];
                hw_d     = win_q;
                hv_d     = HV_1;
                idx_d    = 2'd0;
                r1_d     = R_NONE;
                r2_d     = R_NONE;
                raiser_d = R_NONE;
                state_d  = (full1 || full2) ? OVER : PLAY;
            end
            OVER: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PLAY;
            r1_q     <= R_NONE;
            r2_q     <= R_NONE;
            raiser_q <= R_NONE;
            pend_q   <= R_NONE;
            win_q    <= R_NONE;
            hw_q     <= R_NONE;
            score1_q <= '0;
            score2_q <= '0;
            hv_q     <= HV_1;
            idx_q    <= 2'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            raiser_q <= raiser_d;
            pend_q   <= pend_d;
            win_q    <= win_d;
            hw_q     <= hw_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            hv_q     <= hv_d;
            idx_q    <= idx_d;
            done_q   <= state_q == AWARD;
        end
    end

    assign bus.score1        = score1_q;
    assign bus.score2        = score2_q;
    assign bus.hand_value    = hv_q;
    assign bus.vaza_idx      = idx_q;
    assign bus.truco_pending = state_q == TRUCO_WAIT;
    assign bus.hand_done     = done_q;
    assign bus.hand_winner   = hw_q;
    assign bus.game_over     = state_q == OVER;
endmodule

// File: tb/tb_mao_placar.sv
// tb_mao_placar: vector table, directed corner sequences and a randomized run against a hand-level model
module tb_mao_placar;
    localparam int TARGET = 12;
    localparam logic [6:0] ID = 7'b0000000, P1 = 7'b1100000, P2 = 7'b1000000, TT = 7'b1010000;
    localparam logic [6:0] Q1 = 7'b0001000, Q2 = 7'b0000100, AC = 7'b0000010, RN = 7'b0000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mao_placar_if bus ();
    mao_placar dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [6:0] in;
        int done, hw, s1, s2, hv, idx, pend;
    } vec_t;
    vec_t tbl[$];

    int n_vec = 0, n_err = 0;
    int m_ph, m_s1, m_s2, m_hvi, m_idx, m_raiser, m_pend, m_win, m_hw, m_done;
    int m_res[$];
    int ladder[5] = '{1, 3, 6, 9, 12};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic row(input logic [6:0] in, input int d, hw, s1, s2, hv, idx, pend);
        vec_t v;
        v.in = in; v.done = d; v.hw = hw; v.s1 = s1; v.s2 = s2; v.hv = hv; v.idx = idx; v.pend = pend;
        tbl.push_back(v);
    endtask

    // Hand outcome from the list of vaza results (1=p1, 2=p2, 3=tie): -1 open, 0 no winner
    function automatic int decide(input int q[$]);
        int w1, w2, n, first;
        bit tie;
        w1 = 0; w2 = 0; first = 0; tie = 0; n = q.size();
        for (int i = n - 1; i >= 0; i--) begin
            if (q[i] == 1) w1++;
            if (q[i] == 2) w2++;
            if (q[i] == 3) tie = 1; else first = q[i];
        end
        if (n < 2) return -1;
        if (w1 >= 2) return 1;
        if (w2 >= 2) return 2;
        if (q[0] == 3 && first != 0) return first;
        if (q[0] != 3 && tie) return q[0];
        return n == 3 ? 0 : -1;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_s1 = 0; m_s2 = 0; m_hvi = 0; m_idx = 0;
        m_raiser = 0; m_pend = 0; m_win = 0; m_hw = 0; m_done = 0;
        m_res.delete();
    endtask

    task automatic model_step(input logic [6:0] in);
        logic vv, v, e, q1, q2, acc, run;
        int w;
        {vv, v, e, q1, q2, acc, run} = in;
        m_done = 0;
        case (m_ph)
            0: if (vv) begin
                   m_res.push_back(e ? 3 : v ? 1 : 2);
                   w = decide(m_res);
                   if (w >= 0) begin m_win = w; m_ph = 2; end
                   else m_idx = m_res.size();
               end else if (m_hvi < 4 && q1 && m_raiser != 1) begin m_pend = 1; m_ph = 1; end
               else if (m_hvi < 4 && q2 && m_raiser != 2) begin m_pend = 2; m_ph = 1; end
            1: if (run) begin m_win = m_pend; m_ph = 2; end
               else if (acc) begin m_hvi++; m_raiser = m_pend; m_ph = 0; end
            2: begin
                   if (m_win == 1) m_s1 = (m_s1 + ladder[m_hvi] > TARGET) ? TARGET : m_s1 + ladder[m_hvi];
                   if (m_win == 2) m_s2 = (m_s2 + ladder[m_hvi] > TARGET) ? TARGET : m_s2 + ladder[m_hvi];
                   m_done = 1; m_hw = m_win; m_hvi = 0; m_idx = 0; m_raiser = 0;
                   m_res.delete();
                   m_ph = (m_s1 >= TARGET || m_s2 >= TARGET) ? 3 : 0;
               end
            default: ;
        endcase
    endtask

    task automatic set_in(input logic [6:0] in);
        {bus.vaza_valid, bus.v_in, bus.e_in, bus.truco_req_p1, bus.truco_req_p2,
         bus.truco_acc, bus.truco_run} = in;
    endtask

    task automatic cyc(input logic [6:0] in);
        set_in(in);
        @(posedge clk);
        model_step(in);
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_in(ID);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_model();
        chk("score1", int'(bus.score1), m_s1);
        chk("score2", int'(bus.score2), m_s2);
        chk("hand_value", int'(bus.hand_value), ladder[m_hvi]);
        chk("vaza_idx", int'(bus.vaza_idx), m_idx);
        chk("truco_pending", int'(bus.truco_pending), int'(m_ph == 1));
        chk("hand_done", int'(bus.hand_done), m_done);
        chk("hand_winner", int'(bus.hand_winner), m_hw);
        chk("game_over", int'(bus.game_over), int'(m_ph == 3));
    endtask

    initial begin
        logic [6:0] rin;
        set_in(ID);
        model_reset();
        //  in        done hw s1 s2 hv idx pend
        row(P1,       0, 0, 0, 0, 1, 1, 0);
        row(P1,       0, 0, 0, 0, 1, 1, 0);
        row(ID,       1, 1, 1, 0, 1, 0, 0);
        row(ID,       0, 1, 1, 0, 1, 0, 0);
        row(TT,       0, 1, 1, 0, 1, 1, 0);
        row(P2,       0, 1, 1, 0, 1, 1, 0);
        row(ID,       1, 2, 1, 1, 1, 0, 0);
        row(P1,       0, 2, 1, 1, 1, 1, 0);
        row(TT,       0, 2, 1, 1, 1, 1, 0);
        row(ID,       1, 1, 2, 1, 1, 0, 0);
        row(TT,       0, 1, 2, 1, 1, 1, 0);
        row(TT,       0, 1, 2, 1, 1, 2, 0);
        row(TT,       0, 1, 2, 1, 1, 2, 0);
        row(ID,       1, 0, 2, 1, 1, 0, 0);
        row(Q1,       0, 0, 2, 1, 1, 0, 1);
        row(AC,       0, 0, 2, 1, 3, 0, 0);
        row(Q2,       0, 0, 2, 1, 3, 0, 1);
        row(AC,       0, 0, 2, 1, 6, 0, 0);
        row(Q2,       0, 0, 2, 1, 6, 0, 0);
        row(P2,       0, 0, 2, 1, 6, 1, 0);
        row(P2,       0, 0, 2, 1, 6, 1, 0);
        row(ID,       1, 2, 2, 7, 1, 0, 0);
        row(Q1,       0, 2, 2, 7, 1, 0, 1);
        row(RN,       0, 2, 2, 7, 1, 0, 0);
        row(ID,       1, 1, 3, 7, 1, 0, 0);
        row(Q2,       0, 1, 3, 7, 1, 0, 1);
        row(AC | RN,  0, 1, 3, 7, 1, 0, 0);
        row(ID,       1, 2, 3, 8, 1, 0, 0);
        row(P1 | Q1,  0, 2, 3, 8, 1, 1, 0);
        row(Q1,       0, 2, 3, 8, 1, 1, 1);
        row(P2,       0, 2, 3, 8, 1, 1, 1);
        row(AC,       0, 2, 3, 8, 3, 1, 0);
        row(P1,       0, 2, 3, 8, 3, 1, 0);
        row(ID,       1, 1, 6, 8, 1, 0, 0);

        @(negedge clk);
        @(negedge clk);
        chk("rst_score1", int'(bus.score1), 0);
        chk("rst_score2", int'(bus.score2), 0);
        chk("rst_hand_value", int'(bus.hand_value), 1);
        chk("rst_vaza_idx", int'(bus.vaza_idx), 0);
        chk("rst_pending", int'(bus.truco_pending), 0);
        chk("rst_done", int'(bus.hand_done), 0);
        chk("rst_winner", int'(bus.hand_winner), 0);
        chk("rst_game_over", int'(bus.game_over), 0);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            cyc(tbl[k].in);
            chk($sformatf("row%0d_done", k), int'(bus.hand_done), tbl[k].done);
            chk($sformatf("row%0d_winner", k), int'(bus.hand_winner), tbl[k].hw);
            chk($sformatf("row%0d_score1", k), int'(bus.score1), tbl[k].s1);
            chk($sformatf("row%0d_score2", k), int'(bus.score2), tbl[k].s2);
            chk($sformatf("row%0d_hv", k), int'(bus.hand_value), tbl[k].hv);
            chk($sformatf("row%0d_idx", k), int'(bus.vaza_idx), tbl[k].idx);
            chk($sformatf("row%0d_pending", k), int'(bus.truco_pending), tbl[k].pend);
            chk($sformatf("row%0d_game_over", k), int'(bus.game_over), 0);
        end

        // Drive player 1 from 6 to 10, then win a 3-point mão to saturate at 12
        cyc(Q1); cyc(AC);
        chk("go_hv3a", int'(bus.hand_value), 3);
        cyc(P1); cyc(P1); cyc(ID);
        chk("go_s1_9", int'(bus.score1), 9);
        cyc(P1); cyc(P1); cyc(ID);
        chk("go_s1_10", int'(bus.score1), 10);
        cyc(Q1); cyc(AC);
        chk("go_hv3b", int'(bus.hand_value), 3);
        cyc(P1); cyc(P1); cyc(ID);
        chk("go_s1_sat", int'(bus.score1), 12);
        chk("go_flag", int'(bus.game_over), 1);
        chk("go_done", int'(bus.hand_done), 1);
        chk("go_winner", int'(bus.hand_winner), 1);
        cyc(P2); cyc(P2); cyc(P2); cyc(Q2); cyc(AC); cyc(ID);
        chk("over_s1", int'(bus.score1), 12);
        chk("over_s2", int'(bus.score2), 8);
        chk("over_flag", int'(bus.game_over), 1);
        chk("over_done", int'(bus.hand_done), 0);
        chk("over_pending", int'(bus.truco_pending), 0);

        // Asynchronous reset while a raise to 6 is pending at hand_value 3
        do_reset();
        cyc(P1); cyc(P1); cyc(ID);
        chk("ar_s1", int'(bus.score1), 1);
        cyc(Q1); cyc(AC); cyc(Q2);
        chk("ar_pend_before", int'(bus.truco_pending), 1);
        chk("ar_hv_before", int'(bus.hand_value), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pending", int'(bus.truco_pending), 0);
        chk("ar_hv", int'(bus.hand_value), 1);
        chk("ar_score1", int'(bus.score1), 0);
        chk("ar_score2", int'(bus.score2), 0);
        chk("ar_idx", int'(bus.vaza_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 3000; i++) begin
            if ((m_ph == 3 && $urandom_range(0, 7) == 0) || $urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                rin = {$urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0};
                cyc(rin);
            end
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
